// File: rtl/fringe_gen_4steps.sv
// Four-step phase-shifted fringe pattern generator.
// Emits one beat of four pixels (0, 90, 180, 270 degree shifts) per
// pixel position of a frame, with AXI-stream style framing flags.
module fringe_gen_4steps #(
  parameter int IMG_WIDTH  = 1280,
  parameter int IMG_HEIGHT = 720
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [15:0] phase_start_i,
  input  logic [15:0] phase_inc_i,
  input  logic [7:0]  amp_i,
  input  logic [7:0]  offset_i,
  input  logic        rdy_i,
  output logic        vld_o,
  output logic [7:0]  pixel1_o,
  output logic [7:0]  pixel2_o,
  output logic [7:0]  pixel3_o,
  output logic [7:0]  pixel4_o,
  output logic        tlast_o,
  output logic        tuser_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t         state;
  logic [XW-1:0]  x_cnt;
  logic [YW-1:0]  y_cnt;
  logic [15:0]    ph_acc, ph_start_r, ph_inc_r;
  logic [7:0]     amp_r, off_r;
  logic           adv, emit, fin_hs;
  // bit 0 = coordinate stage, bit 3 = output register
  logic [3:0]     vld_pipe, eol_pipe, sof_pipe, fin_pipe;
  logic [7:0]     k0;
  logic [3:0][7:0]  op1;
  logic [3:0][9:0]  m2;
  logic [3:0][7:0]  pix3;
  logic [7:0]       c_n, s_n;
  logic [3:0][7:0]  op_n;
  logic [3:0][16:0] prod_n;

  // First quadrant of round(127*cos(2*pi*i/256)), i = 0..64.
  function automatic logic [6:0] quarter(input logic [6:0] i);
    logic [6:0] q;
    case (i)
      7'd0:  q = 7'd127; 7'd1:  q = 7'd127; 7'd2:  q = 7'd127; 7'd3:  q = 7'd127;
      7'd4:  q = 7'd126; 7'd5:  q = 7'd126; 7'd6:  q = 7'd126; 7'd7:  q = 7'd125;
      7'd8:  q = 7'd125; 7'd9:  q = 7'd124; 7'd10: q = 7'd123; 7'd11: q = 7'd122;
      7'd12: q = 7'd122; 7'd13: q = 7'd121; 7'd14: q = 7'd120; 7'd15: q = 7'd118;
      7'd16: q = 7'd117; 7'd17: q = 7'd116; 7'd18: q = 7'd115; 7'd19: q = 7'd113;
      7'd20: q = 7'd112; 7'd21: q = 7'd111; 7'd22: q = 7'd109; 7'd23: q = 7'd107;
      7'd24: q = 7'd106; 7'd25: q = 7'd104; 7'd26: q = 7'd102; 7'd27: q = 7'd100;
      7'd28: q = 7'd98;  7'd29: q = 7'd96;  7'd30: q = 7'd94;  7'd31: q = 7'd92;
      7'd32: q = 7'd90;  7'd33: q = 7'd88;  7'd34: q = 7'd85;  7'd35: q = 7'd83;
      7'd36: q = 7'd81;  7'd37: q = 7'd78;  7'd38: q = 7'd76;  7'd39: q = 7'd73;
      7'd40: q = 7'd71;  7'd41: q = 7'd68;  7'd42: q = 7'd65;  7'd43: q = 7'd63;
      7'd44: q = 7'd60;  7'd45: q = 7'd57;  7'd46: q = 7'd54;  7'd47: q = 7'd51;
      7'd48: q = 7'd49;  7'd49: q = 7'd46;  7'd50: q = 7'd43;  7'd51: q = 7'd40;
      7'd52: q = 7'd37;  7'd53: q = 7'd34;  7'd54: q = 7'd31;  7'd55: q = 7'd28;
      7'd56: q = 7'd25;  7'd57: q = 7'd22;  7'd58: q = 7'd19;  7'd59: q = 7'd16;
      7'd60: q = 7'd12;  7'd61: q = 7'd9;   7'd62: q = 7'd6;   7'd63: q = 7'd3;
      default: q = 7'd0;
    endcase
    return q;
  endfunction

  // Full 256-entry signed cosine built from quarter-wave symmetry.
  function automatic logic [7:0] cos_lut(input logic [7:0] k);
    logic [6:0] i_fwd, i_rev;
    logic [7:0] mag;
    i_fwd = {1'b0, k[5:0]};
    i_rev = 7'd64 - i_fwd;
    mag   = {1'b0, (k[6] ? quarter(i_rev) : quarter(i_fwd))};
    return (k[7] ^ k[6]) ? (8'd0 - mag) : mag;
  endfunction

  // A + signed term, clamped to 0..255.
  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [9:0] m);
    logic [10:0] s;
    s = {3'b000, a} + {m[9], m};
    if (s[10])            return 8'd0;
    else if (s[9:8] != 0) return 8'd255;
    else                  return s[7:0];
  endfunction

  assign adv      = ~vld_o | rdy_i;
  assign emit     = (state == RUN);
  assign fin_hs   = vld_pipe[3] & rdy_i & fin_pipe[3];
  assign busy_o   = (state != IDLE);
  assign vld_o    = vld_pipe[3];
  assign tlast_o  = eol_pipe[3];
  assign tuser_o  = sof_pipe[3];
  assign pixel1_o = pix3[0];
  assign pixel2_o = pix3[1];
  assign pixel3_o = pix3[2];
  assign pixel4_o = pix3[3];

  // LUT lookup and per-lane products; lanes are C, -S, -C, S.
  always_comb begin
    c_n     = cos_lut(k0);
    s_n     = cos_lut(k0 - 8'd64);
    op_n[0] = c_n;
    op_n[1] = 8'd0 - s_n;
    op_n[2] = 8'd0 - c_n;
    op_n[3] = s_n;
    // low 17 bits of a sign-extended product equal the signed product
    for (int i = 0; i < 4; i++)
      prod_n[i] = {9'b0, amp_r} * {{9{op1[i][7]}}, op1[i]};
  end

  // Frame FSM: parameter latch, x/y scan and phase accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      x_cnt      <= '0;
      y_cnt      <= '0;
      ph_acc     <= '0;
      ph_start_r <= '0;
      ph_inc_r   <= '0;
      amp_r      <= '0;
      off_r      <= '0;
      done_o     <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: if (start_i) begin
          ph_start_r <= phase_start_i;
          ph_inc_r   <= phase_inc_i;
          amp_r      <= amp_i;
          off_r      <= offset_i;
          ph_acc     <= phase_start_i;
          x_cnt      <= '0;
          y_cnt      <= '0;
          state      <= RUN;
        end
        RUN: if (adv) begin
          if (x_cnt == X_LAST) begin
            x_cnt  <= '0;
            ph_acc <= ph_start_r;
            if (y_cnt == Y_LAST) begin
              y_cnt <= '0;
              state <= DRAIN;
            end else begin
              y_cnt <= y_cnt + YW'(1);
            end
          end else begin
            x_cnt  <= x_cnt + XW'(1);
            ph_acc <= ph_acc + ph_inc_r;
          end
        end
        DRAIN: if (fin_hs) begin
          state  <= IDLE;
          done_o <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Whole pipeline moves together, frozen while output is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      eol_pipe <= '0;
      sof_pipe <= '0;
      fin_pipe <= '0;
      k0       <= '0;
      op1      <= '0;
      m2       <= '0;
      pix3     <= '0;
    end else if (adv) begin
      vld_pipe <= {vld_pipe[2:0], emit};
      eol_pipe <= {eol_pipe[2:0], emit && (x_cnt == X_LAST)};
      sof_pipe <= {sof_pipe[2:0], emit && (x_cnt == '0) && (y_cnt == '0)};
      fin_pipe <= {fin_pipe[2:0], emit && (x_cnt == X_LAST) && (y_cnt == Y_LAST)};
      k0       <= ph_acc[15:8];
      op1      <= op_n;
      for (int i = 0; i < 4; i++) begin
        m2[i]   <= prod_n[i][16:7];
        pix3[i] <= sat_add(off_r, m2[i]);
      end
    end
  end

endmodule

// File: tb/tb_fringe_gen_4steps.sv
// Bench for fringe_gen_4steps on a 4x2 frame: table frames, model frames,
// backpressure, mid-frame reset and ignored start pulses.
module tb_fringe_gen_4steps;
  localparam int W = 4;
  localparam int H = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [15:0] phase_start_i = '0, phase_inc_i = '0;
  logic [7:0]  amp_i = '0, offset_i = '0;
  logic        rdy_i = 1'b1;
  logic        vld_o, tlast_o, tuser_o, busy_o, done_o;
  logic [7:0]  pixel1_o, pixel2_o, pixel3_o, pixel4_o;

  fringe_gen_4steps #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i),
    .phase_start_i(phase_start_i), .phase_inc_i(phase_inc_i),
    .amp_i(amp_i), .offset_i(offset_i), .rdy_i(rdy_i),
    .vld_o(vld_o), .pixel1_o(pixel1_o), .pixel2_o(pixel2_o),
    .pixel3_o(pixel3_o), .pixel4_o(pixel4_o), .tlast_o(tlast_o),
    .tuser_o(tuser_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ps, inc;
    logic [7:0]  a, b;            // a = offset (A), b = amplitude (B)
    logic [0:3][7:0] e1, e2, e3, e4;
  } vec_t;

  typedef struct packed {
    logic [7:0] p1, p2, p3, p4;
    logic       tlast, tuser, fin;
  } beat_t;

  vec_t  tbl[4];
  beat_t sb[$];
  int    errors = 0, checks = 0;
  int    cyc = 0, beats = 0, done_cnt = 0, first_vld = -1, fin_cyc = -10;
  bit    rand_rdy = 1'b0, was_stalled = 1'b0;
  logic [34:0] held = '0;

  task automatic chk(input bit ok, input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] ps, input logic [15:0] inc,
                              input logic [7:0] a, input logic [7:0] b,
                              input logic [31:0] e1, input logic [31:0] e2,
                              input logic [31:0] e3, input logic [31:0] e4);
    vec_t v;
    v.ps = ps; v.inc = inc; v.a = a; v.b = b;
    v.e1 = e1; v.e2 = e2; v.e3 = e3; v.e4 = e4;
    return v;
  endfunction

  function automatic int lut(input int k);
    real v;
    v = 127.0 * $cos(2.0 * 3.14159265358979 * k / 256.0);
    return (v >= 0.0) ? int'($floor(v + 0.5)) : -int'($floor(-v + 0.5));
  endfunction

  function automatic logic [7:0] pix(input int a, input int b, input int m);
    int r;
    r = a + ((b * m) >>> 7);
    if (r < 0) r = 0;
    if (r > 255) r = 255;
    return 8'(r);
  endfunction

  function automatic vec_t model_vec(input logic [15:0] ps, input logic [15:0] inc,
                                     input logic [7:0] a, input logic [7:0] b);
    vec_t v;
    int k, c, s;
    v.ps = ps; v.inc = inc; v.a = a; v.b = b;
    for (int x = 0; x < W; x++) begin
      k = ((int'(ps) + x * int'(inc)) % 65536) >> 8;
      c = lut(k);
      s = lut((k + 192) % 256);
      v.e1[x] = pix(a, b, c);
      v.e2[x] = pix(a, b, -s);
      v.e3[x] = pix(a, b, -c);
      v.e4[x] = pix(a, b, s);
    end
    return v;
  endfunction

  task automatic push_frame(input vec_t v);
    beat_t e;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        e.p1 = v.e1[x]; e.p2 = v.e2[x]; e.p3 = v.e3[x]; e.p4 = v.e4[x];
        e.tlast = (x == W - 1);
        e.tuser = (x == 0 && y == 0);
        e.fin   = (x == W - 1 && y == H - 1);
        sb.push_back(e);
      end
  endtask

  task automatic pulse_start(input vec_t v);
    phase_start_i = v.ps; phase_inc_i = v.inc; offset_i = v.a; amp_i = v.b;
    @(posedge clk) #1 start_i = 1'b1;
    @(posedge clk) #1 start_i = 1'b0;
    // later input changes must not affect the running frame
    phase_start_i = 16'($urandom); phase_inc_i = 16'($urandom);
    offset_i = 8'($urandom); amp_i = 8'($urandom);
  endtask

  task automatic run_frame(input vec_t v, input bit rnd);
    int d0, st, t;
    push_frame(v);
    rand_rdy = rnd; beats = 0; first_vld = -1; d0 = done_cnt;
    pulse_start(v);
    st = cyc;
    for (t = 0; t < 400 && done_cnt == d0; t++) @(posedge clk);
    chk(done_cnt != d0, "timeout", 64'(t), 64'd400);
    repeat (3) @(posedge clk);
    rand_rdy = 1'b0;
    chk(done_cnt == d0 + 1, "done_count", 64'(done_cnt - d0), 64'd1);
    chk(beats == W * H, "beat_count", 64'(beats), 64'(W * H));
    chk(sb.size() == 0, "sb_empty", 64'(sb.size()), 64'd0);
    chk(first_vld - st == 4, "first_vld_lat", 64'(first_vld - st), 64'd4);
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    #1 rdy_i = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Output monitor: scoreboard pop on handshake, hold check while stalled.
  always @(negedge clk) begin
    logic [34:0] cur;
    beat_t e;
    cur = {vld_o, pixel1_o, pixel2_o, pixel3_o, pixel4_o, tlast_o, tuser_o};
    if (!rst_n) begin
      was_stalled = 1'b0;
    end else begin
      if (was_stalled) chk(cur == held, "stall_hold", 64'(cur), 64'(held));
      if (vld_o && first_vld < 0) first_vld = cyc;
      if (vld_o && rdy_i) begin
        beats++;
        chk(sb.size() != 0, "unexpected_beat", 64'(cur), 64'd0);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk(cur[33:0] == {e.p1, e.p2, e.p3, e.p4, e.tlast, e.tuser}, "beat",
              64'(cur[33:0]), 64'({e.p1, e.p2, e.p3, e.p4, e.tlast, e.tuser}));
          if (e.fin) fin_cyc = cyc;
        end
      end
      was_stalled = vld_o && !rdy_i;
      held = cur;
      if (done_o) begin
        done_cnt++;
        chk(cyc == fin_cyc + 1, "done_timing", 64'(cyc), 64'(fin_cyc + 1));
      end
    end
  end

  initial begin
    int t, b0;
    vec_t v;
    tbl[0] = mk(16'h0000, 16'h0000, 8'd128, 8'd100,
                {8'd227, 8'd227, 8'd227, 8'd227}, {8'd128, 8'd128, 8'd128, 8'd128},
                {8'd28, 8'd28, 8'd28, 8'd28},     {8'd128, 8'd128, 8'd128, 8'd128});
    tbl[1] = mk(16'h0000, 16'h4000, 8'd128, 8'd100,
                {8'd227, 8'd128, 8'd28, 8'd128},  {8'd128, 8'd28, 8'd128, 8'd227},
                {8'd28, 8'd128, 8'd227, 8'd128},  {8'd128, 8'd227, 8'd128, 8'd28});
    tbl[2] = mk(16'h0000, 16'h0000, 8'd200, 8'd255,
                {8'd255, 8'd255, 8'd255, 8'd255}, {8'd200, 8'd200, 8'd200, 8'd200},
                {8'd0, 8'd0, 8'd0, 8'd0},         {8'd200, 8'd200, 8'd200, 8'd200});
    tbl[3] = mk(16'h8000, 16'hC000, 8'd10, 8'd20,
                {8'd0, 8'd10, 8'd29, 8'd10},      {8'd10, 8'd0, 8'd10, 8'd29},
                {8'd29, 8'd10, 8'd0, 8'd10},      {8'd10, 8'd29, 8'd10, 8'd0});

    // reset state
    repeat (3) @(posedge clk);
    #1 chk({vld_o, tlast_o, tuser_o, busy_o, done_o} == 5'b0, "reset_flags",
           64'({vld_o, tlast_o, tuser_o, busy_o, done_o}), 64'd0);
    chk({pixel1_o, pixel2_o, pixel3_o, pixel4_o} == 32'b0, "reset_pixels",
        64'({pixel1_o, pixel2_o, pixel3_o, pixel4_o}), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // table frames, then backpressure on the varying-phase frames
    for (int i = 0; i < 4; i++) run_frame(tbl[i], 1'b0);
    run_frame(tbl[1], 1'b1);
    run_frame(tbl[3], 1'b1);

    // arbitrary parameters against the real-valued model
    for (int i = 0; i < 3; i++) begin
      v = model_vec(16'($urandom), 16'($urandom), 8'($urandom), 8'($urandom));
      run_frame(v, i[0]);
    end

    // reset after beat 3: outputs drop at once, no stale beats afterwards
    push_frame(tbl[1]);
    beats = 0;
    pulse_start(tbl[1]);
    for (t = 0; t < 100 && beats < 3; t++) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk({vld_o, tlast_o, tuser_o, busy_o, done_o} == 5'b0, "midreset_flags",
           64'({vld_o, tlast_o, tuser_o, busy_o, done_o}), 64'd0);
    chk({pixel1_o, pixel2_o, pixel3_o, pixel4_o} == 32'b0, "midreset_pixels",
        64'({pixel1_o, pixel2_o, pixel3_o, pixel4_o}), 64'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    b0 = beats;
    repeat (20) @(posedge clk);
    chk(beats == b0, "no_beats_after_reset", 64'(beats), 64'(b0));
    run_frame(tbl[1], 1'b0);

    // start pulses in RUN, DRAIN and on the final handshake are ignored
    push_frame(tbl[0]);
    beats = 0;
    b0 = done_cnt;
    pulse_start(tbl[0]);
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk) #1;
      start_i = (c == 2 || c == 9 || c == 11);
      amp_i = 8'd0; offset_i = 8'd7; phase_inc_i = 16'h1234;
    end
    start_i = 1'b0;
    chk(done_cnt == b0 + 1, "ignored_start_done", 64'(done_cnt - b0), 64'd1);
    chk(beats == W * H, "ignored_start_beats", 64'(beats), 64'(W * H));
    chk(sb.size() == 0, "ignored_start_sb", 64'(sb.size()), 64'd0);
    chk(busy_o == 1'b0, "idle_after", 64'(busy_o), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
